// File: rtl/timer_ctrl_if.sv
// Bundles the timer_ctrl request/response signals and the downstream counter hook-up.
// Latency: none, wiring only.
// Backpressure: none; start is dropped when the timer is busy, no handshake is stalled.
interface timer_ctrl_if #(
  parameter int COUNT_WIDTH    = 5,
  parameter int PRESCALE_WIDTH = 4
);
  // control requests
  logic                      start;
  logic                      stop;
  logic                      auto_reload;
  logic [COUNT_WIDTH-1:0]    period;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      irq_clr;
  // downstream down-counter value fed back to the timer
  logic [COUNT_WIDTH-1:0]    count;
  // timer outputs
  logic                      cnt_load;
  logic [COUNT_WIDTH-1:0]    cnt_load_in;
  logic                      cnt_en;
  logic                      busy;
  logic                      expire;
  logic                      irq;

  // environment side: issues requests, owns the down-counter
  modport master (
    output start, stop, auto_reload, period, prescale, irq_clr, count,
    input  cnt_load, cnt_load_in, cnt_en, busy, expire, irq
  );

  // timer side
  modport slave (
    input  start, stop, auto_reload, period, prescale, irq_clr, count,
    output cnt_load, cnt_load_in, cnt_en, busy, expire, irq
  );
endinterface

// File: rtl/timer_ctrl.sv
// Sequences an external down-counter: load, prescaled enables, expiry pulse and sticky irq.
// Latency: start at cycle 0 -> cnt_load at 1 -> expire at N*(P+1)+3; auto-reload repeats at that interval.
// Backpressure: none; start is ignored while busy, stop aborts to IDLE on the next edge.
// Build option: define TIMER_CTRL_PRESCALE_EN to enable the prescaler, otherwise it behaves as P=0.
module timer_ctrl #(
  parameter int COUNT_WIDTH    = 5,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  timer_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   irq_q, irq_d;
  logic                   tick;
  logic                   count_zero;
  logic                   start_acc;

  assign count_zero = (bus.count == '0);
  // start is only looked at in IDLE; a start while busy is simply dropped
  assign start_acc  = (state_q == IDLE) && bus.start;

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;

  // prescale value and prescaler counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale_q  <= '0;
      presc_cnt_q <= '0;
    end else begin
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
    end
  end

  // latch divide value on accepted start; count 0..P only while running, held at 0 elsewhere
  always_comb begin
    prescale_d  = prescale_q;
    presc_cnt_d = '0;
    if (start_acc) begin
      prescale_d = bus.prescale;
    end
    if (state_q == RUN) begin
      if (presc_cnt_q == prescale_q) begin
        presc_cnt_d = '0;
      end else begin
        presc_cnt_d = PRESCALE_WIDTH'(presc_cnt_q + 1'b1);
      end
    end
  end

  assign tick = (state_q == RUN) && (presc_cnt_q == prescale_q);
`else
  // prescale input is kept on the interface for pin compatibility but has no effect here
  logic unused_prescale;
  assign unused_prescale = ^bus.prescale;
  assign tick            = (state_q == RUN);
`endif

  // state, latched period and sticky irq registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      irq_q    <= irq_d;
    end
  end

  // next-state: stop beats expiry, start beats stop in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: state_d = bus.stop ? IDLE : RUN;
      RUN: begin
        if (bus.stop)       state_d = IDLE;
        else if (count_zero) state_d = DONE;
      end
      DONE: begin
        if (bus.stop)            state_d = IDLE;
        else if (bus.auto_reload) state_d = LOAD;
        else                      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // period latch and irq: an expiry in the same cycle as irq_clr keeps irq set
  always_comb begin
    period_d = period_q;
    irq_d    = irq_q;
    if (start_acc) begin
      period_d = bus.period;
    end
    if (state_q == DONE) begin
      irq_d = 1'b1;
    end else if (bus.irq_clr) begin
      irq_d = 1'b0;
    end
  end

  // outputs decoded from registered state; cnt_en also masked by count so the counter never wraps
  always_comb begin
    bus.cnt_load    = (state_q == LOAD);
    bus.cnt_en      = tick && !count_zero;
    bus.busy        = (state_q != IDLE);
    bus.expire      = (state_q == DONE);
    bus.irq         = irq_q;
    bus.cnt_load_in = period_q;
  end

endmodule
